// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, RV32I opcodes,
// datapath mux selects and the ALU operation codes.
package mc_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_BR   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SLR = 4'd6,
    ALU_BEQ = 4'd7,
    ALU_BNE = 4'd8,
    ALU_BLT = 4'd9,
    ALU_BGE = 4'd10
  } alu_op_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_OLD_PC = 2'd1,
    SRC_A_REG    = 2'd2
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_REG  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } wb_src_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction fields and status in, mux
// selects, write strobes and debug/status flags out.
interface mc_control_unit_if;

  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic       funct7_5_i;
  logic       bcond_i;
  logic       mem_ready_i;
  logic       halt_req_i;

  logic [3:0] alu_op_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] wb_src_o;
  logic       pc_write_o;
  logic       ir_write_o;
  logic       aluout_write_o;
  logic       reg_write_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       i_or_d_o;
  logic       retire_o;
  logic       halted_o;
  logic       illegal_o;
  logic [2:0] state_o;

  // Control unit side.
  modport master (
    input  opcode_i, funct3_i, funct7_5_i, bcond_i, mem_ready_i, halt_req_i,
    output alu_op_o, alu_src_a_o, alu_src_b_o, wb_src_o,
    output pc_write_o, ir_write_o, aluout_write_o, reg_write_o,
    output mem_read_o, mem_write_o, i_or_d_o, retire_o,
    output halted_o, illegal_o, state_o
  );

  // Datapath side.
  modport slave (
    output opcode_i, funct3_i, funct7_5_i, bcond_i, mem_ready_i, halt_req_i,
    input  alu_op_o, alu_src_a_o, alu_src_b_o, wb_src_o,
    input  pc_write_o, ir_write_o, aluout_write_o, reg_write_o,
    input  mem_read_o, mem_write_o, i_or_d_o, retire_o,
    input  halted_o, illegal_o, state_o
  );

endinterface

// File: rtl/mc_control_unit_alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7_5 into the ALU operation used
// in EX, plus a flag for encodings the core does not implement.
module alu_op_decode
  import mc_control_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_t    alu_op,
  output logic       illegal
);

  // Select the ALU operation from the instruction class and funct fields.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned, which would infer a latch.
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ITYPE: begin
        case (funct3)
          3'b000:  alu_op = (opcode == OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = ALU_SLR;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  alu_op = ALU_BEQ;
          3'b001:  alu_op = ALU_BNE;
          3'b100:  alu_op = ALU_BLT;
          3'b101:  alu_op = ALU_BGE;
          default: illegal = 1'b1;
        endcase
      end
      // Address and link arithmetic is a plain add; ECALL uses no ALU op.
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_ECALL: alu_op = ALU_ADD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: sequences each instruction through IF/ID/EX/BR/MEM/WB,
// drives the datapath muxes and strobes, and halts on ECALL or illegal encodings.
module mc_control_unit
  import mc_control_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mc_control_unit_if.master  bus
);

  state_t  state;
  logic    halted;
  logic    illegal;
  alu_op_t dec_op;
  logic    dec_illegal;

  logic is_rtype, is_itype, is_load, is_store, is_branch, is_jal, is_jalr, is_ecall;

  assign is_rtype  = (bus.opcode_i == OP_RTYPE);
  assign is_itype  = (bus.opcode_i == OP_ITYPE);
  assign is_load   = (bus.opcode_i == OP_LOAD);
  assign is_store  = (bus.opcode_i == OP_STORE);
  assign is_branch = (bus.opcode_i == OP_BRANCH);
  assign is_jal    = (bus.opcode_i == OP_JAL);
  assign is_jalr   = (bus.opcode_i == OP_JALR);
  assign is_ecall  = (bus.opcode_i == OP_ECALL);

  alu_op_decode u_alu_op_decode (
    .opcode   (bus.opcode_i),
    .funct3   (bus.funct3_i),
    .funct7_5 (bus.funct7_5_i),
    .alu_op   (dec_op),
    .illegal  (dec_illegal)
  );

  // State register and sticky halt/illegal flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IF;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IF:  if (bus.mem_ready_i) state <= S_ID;
        S_ID: begin
          if (is_ecall) begin
            if (bus.halt_req_i) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state <= S_IF;
            end
          end else if (dec_illegal) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else begin
            state <= S_EX;
          end
        end
        S_EX: begin
          if (is_rtype || is_itype)       state <= S_WB;
          else if (is_load || is_store)   state <= S_MEM;
          else if (is_branch && bus.bcond_i) state <= S_BR;
          else                            state <= S_IF;
        end
        S_BR:   state <= S_IF;
        S_MEM:  if (bus.mem_ready_i) state <= is_load ? S_WB : S_IF;
        S_WB:   state <= S_IF;
        S_HALT: state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // Datapath controls, combinational from state, decode and handshake inputs.
  always_comb begin
    bus.alu_op_o       = ALU_ADD;
    bus.alu_src_a_o    = SRC_A_PC;
    bus.alu_src_b_o    = SRC_B_REG;
    bus.wb_src_o       = WB_ALUOUT;
    bus.pc_write_o     = 1'b0;
    bus.ir_write_o     = 1'b0;
    bus.aluout_write_o = 1'b0;
    bus.reg_write_o    = 1'b0;
    bus.mem_read_o     = 1'b0;
    bus.mem_write_o    = 1'b0;
    bus.i_or_d_o       = 1'b0;
    bus.retire_o       = 1'b0;
    // Reset aborts the current instruction, so nothing is driven while it is held.
    if (!reset) begin
      case (state)
        S_IF: begin
          bus.mem_read_o  = 1'b1;
          bus.alu_src_b_o = SRC_B_FOUR;
          bus.ir_write_o  = bus.mem_ready_i;
          bus.pc_write_o  = bus.mem_ready_i;
        end
        S_ID: bus.retire_o = is_ecall && !bus.halt_req_i;
        S_EX: begin
          bus.alu_src_a_o = SRC_A_REG;
          bus.alu_op_o    = dec_op;
          if (is_rtype) begin
            bus.aluout_write_o = 1'b1;
          end else if (is_itype || is_load || is_store) begin
            bus.alu_src_b_o    = SRC_B_IMM;
            bus.aluout_write_o = 1'b1;
          end else if (is_branch) begin
            // Not taken: PC already holds PC + 4 from IF.
            bus.retire_o = !bus.bcond_i;
          end else if (is_jal || is_jalr) begin
            // Register file captures the pre-edge PC (the link) as the PC is overwritten.
            bus.alu_src_a_o = is_jal ? SRC_A_OLD_PC : SRC_A_REG;
            bus.alu_src_b_o = SRC_B_IMM;
            bus.pc_write_o  = 1'b1;
            bus.reg_write_o = 1'b1;
            bus.wb_src_o    = WB_PC;
            bus.retire_o    = 1'b1;
          end
        end
        S_BR: begin
          bus.alu_src_a_o = SRC_A_OLD_PC;
          bus.alu_src_b_o = SRC_B_IMM;
          bus.pc_write_o  = 1'b1;
          bus.retire_o    = 1'b1;
        end
        S_MEM: begin
          bus.i_or_d_o    = 1'b1;
          bus.mem_read_o  = is_load;
          bus.mem_write_o = is_store;
          bus.retire_o    = is_store && bus.mem_ready_i;
        end
        S_WB: begin
          bus.reg_write_o = 1'b1;
          bus.wb_src_o    = is_load ? WB_MDR : WB_ALUOUT;
          bus.retire_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.halted_o  = halted;
  assign bus.illegal_o = illegal;
  assign bus.state_o   = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: expected per-cycle control traces
// are built from the instruction class and the memory wait counts.
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Strobe bit positions: {pc_write, ir_write, aluout_write, reg_write, mem_read, mem_write, i_or_d, retire}
  localparam logic [7:0] PCW = 8'h80, IRW = 8'h40, AOW = 8'h20, RW = 8'h10;
  localparam logic [7:0] MR  = 8'h08, MW  = 8'h04, IOD = 8'h02, RET = 8'h01, NONE = 8'h00;

  localparam logic [2:0] T_IF = 3'd0, T_ID = 3'd1, T_EX = 3'd2, T_BR = 3'd3;
  localparam logic [2:0] T_MEM = 3'd4, T_WB = 3'd5, T_HALT = 3'd6;

  localparam logic [1:0] A_PC = 2'd0, A_OLD = 2'd1, A_REG = 2'd2;
  localparam logic [1:0] B_REG = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
  localparam logic [1:0] W_ALU = 2'd0, W_MDR = 2'd1, W_PC = 2'd2;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_ECALL} kind_t;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_halted = 1'b0;
  logic exp_illegal = 1'b0;

  logic [6:0] cur_opc = 7'd0;
  logic [2:0] cur_f3 = 3'd0;
  logic       cur_f75 = 1'b0;

  logic [2:0] alu_f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] br_f3s  [4] = '{3'd0, 3'd1, 3'd4, 3'd5};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] kind_opc(input kind_t k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_ST:    return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      default: return 7'b1110011;
    endcase
  endfunction

  // Reference ALU operation for the EX cycle of a legal instruction.
  function automatic logic [3:0] ref_op(input kind_t k, input logic [2:0] f3, input logic f75);
    if (k == K_R || k == K_I) begin
      case (f3)
        3'd0:    return (k == K_R && f75) ? ALU_SUB : ALU_ADD;
        3'd1:    return ALU_SLL;
        3'd4:    return ALU_XOR;
        3'd5:    return ALU_SLR;
        3'd6:    return ALU_OR;
        default: return ALU_AND;
      endcase
    end
    if (k == K_BR) begin
      case (f3)
        3'd0:    return ALU_BEQ;
        3'd1:    return ALU_BNE;
        3'd4:    return ALU_BLT;
        default: return ALU_BGE;
      endcase
    end
    return ALU_ADD;
  endfunction

  function automatic logic [22:0] observe();
    return {bus.state_o, bus.alu_op_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.wb_src_o,
            bus.pc_write_o, bus.ir_write_o, bus.aluout_write_o, bus.reg_write_o,
            bus.mem_read_o, bus.mem_write_o, bus.i_or_d_o, bus.retire_o,
            bus.halted_o, bus.illegal_o};
  endfunction

  task automatic check_now(input logic [2:0] st, input logic [3:0] op, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] wb, input logic [7:0] strb,
                           input string tag);
    logic [22:0] act, exp;
    act = observe();
    exp = {st, op, a, b, wb, strb, exp_halted, exp_illegal};
    n_checks++;
    assert (act === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, compare shortly after.
  task automatic cyc(input logic [2:0] st, input logic [3:0] op, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] wb, input logic [7:0] strb,
                     input logic rdy, input logic bc, input logic hr, input string tag);
    @(negedge clk);
    bus.opcode_i    = cur_opc;
    bus.funct3_i    = cur_f3;
    bus.funct7_5_i  = cur_f75;
    bus.mem_ready_i = rdy;
    bus.bcond_i     = bc;
    bus.halt_req_i  = hr;
    #1;
    check_now(st, op, a, b, wb, strb, tag);
  endtask

  task automatic fetch(input int w_if, input string tag);
    for (int i = 0; i < w_if; i++)
      cyc(T_IF, ALU_ADD, A_PC, B_FOUR, W_ALU, MR, 1'b0, rb(), rb(), {tag, "/if_wait"});
    cyc(T_IF, ALU_ADD, A_PC, B_FOUR, W_ALU, MR | IRW | PCW, 1'b1, rb(), rb(), {tag, "/if"});
  endtask

  // Expected trace for one legal instruction (or ECALL) from fetch to retire/halt.
  task automatic run_instr(input kind_t k, input logic [2:0] f3, input logic f75, input int w_if,
                           input int w_mem, input logic bc, input logic hr, input string tag);
    logic [3:0] op;
    cur_opc = kind_opc(k);
    cur_f3  = f3;
    cur_f75 = f75;
    fetch(w_if, tag);
    if (k == K_ECALL) begin
      cyc(T_ID, ALU_ADD, A_PC, B_REG, W_ALU, hr ? NONE : RET, rb(), rb(), hr, {tag, "/id"});
      if (hr) exp_halted = 1'b1;
      return;
    end
    cyc(T_ID, ALU_ADD, A_PC, B_REG, W_ALU, NONE, rb(), rb(), rb(), {tag, "/id"});
    op = ref_op(k, f3, f75);
    case (k)
      K_R: begin
        cyc(T_EX, op, A_REG, B_REG, W_ALU, AOW, rb(), rb(), rb(), {tag, "/ex"});
        cyc(T_WB, ALU_ADD, A_PC, B_REG, W_ALU, RW | RET, rb(), rb(), rb(), {tag, "/wb"});
      end
      K_I: begin
        cyc(T_EX, op, A_REG, B_IMM, W_ALU, AOW, rb(), rb(), rb(), {tag, "/ex"});
        cyc(T_WB, ALU_ADD, A_PC, B_REG, W_ALU, RW | RET, rb(), rb(), rb(), {tag, "/wb"});
      end
      K_LD, K_ST: begin
        cyc(T_EX, ALU_ADD, A_REG, B_IMM, W_ALU, AOW, rb(), rb(), rb(), {tag, "/ex"});
        for (int i = 0; i < w_mem; i++)
          cyc(T_MEM, ALU_ADD, A_PC, B_REG, W_ALU, IOD | ((k == K_LD) ? MR : MW),
              1'b0, rb(), rb(), {tag, "/mem_wait"});
        cyc(T_MEM, ALU_ADD, A_PC, B_REG, W_ALU, IOD | ((k == K_LD) ? MR : (MW | RET)),
            1'b1, rb(), rb(), {tag, "/mem"});
        if (k == K_LD)
          cyc(T_WB, ALU_ADD, A_PC, B_REG, W_MDR, RW | RET, rb(), rb(), rb(), {tag, "/wb"});
      end
      K_BR: begin
        cyc(T_EX, op, A_REG, B_REG, W_ALU, bc ? NONE : RET, rb(), bc, rb(), {tag, "/ex"});
        if (bc)
          cyc(T_BR, ALU_ADD, A_OLD, B_IMM, W_ALU, PCW | RET, rb(), rb(), rb(), {tag, "/br"});
      end
      K_JAL:
        cyc(T_EX, ALU_ADD, A_OLD, B_IMM, W_PC, PCW | RW | RET, rb(), rb(), rb(), {tag, "/ex"});
      default:
        cyc(T_EX, ALU_ADD, A_REG, B_IMM, W_PC, PCW | RW | RET, rb(), rb(), rb(), {tag, "/ex"});
    endcase
  endtask

  task automatic run_illegal(input logic [6:0] opc, input logic [2:0] f3, input string tag);
    cur_opc = opc;
    cur_f3  = f3;
    cur_f75 = 1'b0;
    fetch(0, tag);
    cyc(T_ID, ALU_ADD, A_PC, B_REG, W_ALU, NONE, rb(), rb(), rb(), {tag, "/id"});
    exp_halted  = 1'b1;
    exp_illegal = 1'b1;
  endtask

  task automatic halt_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++)
      cyc(T_HALT, ALU_ADD, A_PC, B_REG, W_ALU, NONE, rb(), rb(), rb(), tag);
  endtask

  // Assert reset between clock edges and expect the immediate return to IF.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    bus.mem_ready_i = 1'b1;
    #1;
    exp_halted  = 1'b0;
    exp_illegal = 1'b0;
    check_now(T_IF, ALU_ADD, A_PC, B_REG, W_ALU, NONE, tag);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    kind_t k;
    logic [2:0] f3;
    reset = 1'b1;
    bus.opcode_i = 7'd0; bus.funct3_i = 3'd0; bus.funct7_5_i = 1'b0;
    bus.bcond_i = 1'b0; bus.mem_ready_i = 1'b0; bus.halt_req_i = 1'b0;

    // Strobes stay low while reset is held, even with memory ready in IF.
    for (int i = 0; i < 3; i++)
      cyc(T_IF, ALU_ADD, A_PC, B_REG, W_ALU, NONE, 1'b1, 1'b0, 1'b0, "reset_hold");
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    reset = 1'b0;

    // Directed cases.
    run_instr(K_R,    3'd0, 1'b0, 0, 0, 1'b0, 1'b0, "add");
    run_instr(K_R,    3'd0, 1'b1, 0, 0, 1'b0, 1'b0, "sub");
    run_instr(K_BR,   3'd0, 1'b0, 0, 0, 1'b1, 1'b0, "beq_taken");
    run_instr(K_BR,   3'd0, 1'b0, 0, 0, 1'b0, 1'b0, "beq_not_taken");
    run_instr(K_LD,   3'd2, 1'b0, 0, 2, 1'b0, 1'b0, "load_wait2");
    run_instr(K_ST,   3'd2, 1'b0, 1, 2, 1'b0, 1'b0, "store_wait2");
    run_instr(K_JAL,  3'd0, 1'b0, 0, 0, 1'b0, 1'b0, "jal");
    run_instr(K_JALR, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, "jalr");
    run_instr(K_I,    3'd0, 1'b1, 0, 0, 1'b0, 1'b0, "addi_f75");
    run_instr(K_ECALL, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, "ecall_continue");

    // Randomized legal instruction stream with random memory waits.
    for (int n = 0; n < 150; n++) begin
      k = kind_t'($urandom_range(0, 6));
      case (k)
        K_R, K_I: f3 = alu_f3s[$urandom_range(0, 5)];
        K_BR:     f3 = br_f3s[$urandom_range(0, 3)];
        default:  f3 = 3'($urandom_range(0, 7));
      endcase
      run_instr(k, f3, rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                rb(), 1'b0, "rand");
    end

    // Illegal opcode, then reset mid-cycle.
    run_illegal(7'h7F, 3'd0, "illegal_opcode");
    halt_cycles(3, "illegal_opcode/halt");
    async_reset("reset_after_illegal_opcode");

    // Unsupported R-type funct3.
    run_illegal(7'b0110011, 3'b010, "illegal_funct3");
    halt_cycles(2, "illegal_funct3/halt");
    async_reset("reset_after_illegal_funct3");

    // Illegal branch funct3.
    run_illegal(7'b1100011, 3'b010, "illegal_branch_f3");
    halt_cycles(2, "illegal_branch_f3/halt");
    async_reset("reset_after_illegal_branch");

    // ECALL with the halt request: stays halted with no strobes.
    run_instr(K_ECALL, 3'd0, 1'b0, 1, 0, 1'b0, 1'b1, "ecall_halt");
    halt_cycles(12, "ecall_halt/halt");
    async_reset("reset_after_halt");

    // Back to normal execution after reset.
    run_instr(K_R, 3'd7, 1'b0, 0, 0, 1'b0, 1'b0, "and_after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
